// File: rtl/axis_div_if.sv
// AXI-Stream bundle shared by the divider ports.
// The master drives data, user and valid; the slave returns ready.
interface axis_div_if #(
    parameter int DW = 32
) ();
    logic [DW-1:0] tdata;
    logic          tuser;
    logic          tvalid;
    logic          tready;

    modport master (
        output tdata,
        output tuser,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tuser,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/axis_div.sv
// Stream unsigned divider: radix-2 restoring, one quotient bit per cycle.
// Input beat {divisor, dividend}; output beat {remainder, quotient}, tuser = div-by-zero.
module axis_div #(
    parameter int VAR_WIDTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    axis_div_if.slave   s_axis,
    axis_div_if.master  m_axis
);
    localparam int W  = VAR_WIDTH;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [W:0]       r_q, r_d;
    logic [W-1:0]     q_q, q_d;
    logic [W-1:0]     d_q, d_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             s_rdy_q;
    logic             m_vld_q, m_vld_d;
    logic [2*W-1:0]   m_dat_q, m_dat_d;
    logic             m_usr_q, m_usr_d;

    logic             in_hs;
    logic             out_hs;
    logic             div0;
    logic             last;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_d;
    logic [W+1:0]     shf;
    logic [W+1:0]     trial;
    logic             fits;
    logic [W:0]       r_new;
    logic [W-1:0]     q_new;

    assign in_a   = s_axis.tdata[W-1:0];
    assign in_d   = s_axis.tdata[2*W-1:W];
    assign in_hs  = s_axis.tvalid & s_rdy_q;
    assign out_hs = m_vld_q & m_axis.tready;
    assign div0   = (in_d == '0);
    assign last   = (cnt_q == CW'(1));

    // R never exceeds the divisor, so the top bit of shf is zero; the
    // extra bit makes a negative trial show up as trial[W+1].
    assign shf   = {r_q, q_q[W-1]};
    assign trial = shf - {2'b00, d_q};
    assign fits  = ~trial[W+1];
    assign r_new = fits ? trial[W:0] : shf[W:0];
    assign q_new = {q_q[W-2:0], fits};

    assign s_axis.tready = s_rdy_q;
    assign m_axis.tvalid = m_vld_q;
    assign m_axis.tdata  = m_dat_q;
    assign m_axis.tuser  = m_usr_q;

    // State and datapath registers; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            s_rdy_q <= 1'b0;
            m_vld_q <= 1'b0;
            m_dat_q <= '0;
            m_usr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            s_rdy_q <= (state_d == IDLE);
            m_vld_q <= m_vld_d;
            m_dat_q <= m_dat_d;
            m_usr_q <= m_usr_d;
        end
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (in_hs) begin
                    state_d = div0 ? DONE : CALC;
                end
            end
            CALC: begin
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_hs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath update and registered output values per state.
    always_comb begin
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        m_vld_d = m_vld_q;
        m_dat_d = m_dat_q;
        m_usr_d = m_usr_q;
        unique case (state_q)
            IDLE: begin
                if (in_hs) begin
                    d_d   = in_d;
                    cnt_d = CW'(W);
                    if (div0) begin
                        q_d = '1;
                        r_d = {1'b0, in_a};
                    end else begin
                        q_d = in_a;
                        r_d = '0;
                    end
                end
            end
            CALC: begin
                r_d   = r_new;
                q_d   = q_new;
                cnt_d = cnt_q - CW'(1);
                if (last) begin
                    m_dat_d = {r_new[W-1:0], q_new};
                    m_usr_d = 1'b0;
                    m_vld_d = 1'b1;
                end
            end
            DONE: begin
                // Only a zero divisor reaches DONE without a loaded result.
                if (!m_vld_q) begin
                    m_dat_d = {r_q[W-1:0], q_q};
                    m_usr_d = 1'b1;
                    m_vld_d = 1'b1;
                end else if (out_hs) begin
                    m_vld_d = 1'b0;
                end
            end
            default: begin
                m_vld_d = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_axis_div.sv
// Bench for axis_div: directed corner beats, backpressure, mid-op reset,
// then random traffic scored against a plain / and % reference.
module tb_axis_div;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axis_div_if #(.DW(2 * W)) s_if ();
    axis_div_if #(.DW(2 * W)) m_if ();

    axis_div #(.VAR_WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .s_axis (s_if),
        .m_axis (m_if)
    );

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         u;
        int           k;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   n_in = 0;
    int   n_out = 0;
    logic done_r = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: output side first, then input side, on the
    // falling edge while both buses are stable.
    logic             prev_v = 1'b0;
    logic             held = 1'b0;
    logic             rdy_chk = 1'b0;
    logic [2*W-1:0]   hd;
    logic             hu;
    always @(negedge clk) begin
        if (rdy_chk) chk("s_ready_after_out", 64'(s_if.tready), 64'd1);
        rdy_chk = 1'b0;
        if (!rst_n) begin
            prev_v = 1'b0;
            held = 1'b0;
        end else begin
            if (sb.size() != 0) chk("s_ready_low_busy", 64'(s_if.tready), 64'd0);
            if (m_if.tvalid) begin
                if (!prev_v) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_output: got %0h want none", m_if.tdata);
                    end else begin
                        chk("latency", 64'(cyc - sb[0].k), 64'(sb[0].lat));
                    end
                end
                if (held) begin
                    chk("stable_tdata", 64'(m_if.tdata), 64'(hd));
                    chk("stable_tuser", 64'(m_if.tuser), 64'(hu));
                end
                if (m_if.tready && sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("quotient", 64'(m_if.tdata[W-1:0]), 64'(e.q));
                    chk("remainder", 64'(m_if.tdata[2*W-1:W]), 64'(e.r));
                    chk("tuser", 64'(m_if.tuser), 64'(e.u));
                    n_out++;
                    rdy_chk = 1'b1;
                end
            end
            held = m_if.tvalid && !m_if.tready;
            hd = m_if.tdata;
            hu = m_if.tuser;
            prev_v = m_if.tvalid;
            if (s_if.tvalid && s_if.tready) begin
                exp_t e;
                logic [W-1:0] a;
                logic [W-1:0] d;
                a = s_if.tdata[W-1:0];
                d = s_if.tdata[2*W-1:W];
                e.k = cyc + 1;
                if (d == 0) begin
                    e.q = '1;
                    e.r = a;
                    e.u = 1'b1;
                    e.lat = 1;
                end else begin
                    e.q = a / d;
                    e.r = a % d;
                    e.u = 1'b0;
                    e.lat = W;
                end
                sb.push_back(e);
                n_in++;
            end
        end
    end

    task automatic wait_in_hs();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (s_if.tvalid && s_if.tready) begin
                @(posedge clk);
                #1;
                s_if.tvalid = 1'b0;
                return;
            end
        end
        total++;
        bad++;
        $display("FAIL in_timeout: got no handshake want handshake");
        s_if.tvalid = 1'b0;
    endtask

    task automatic send(logic [W-1:0] d, logic [W-1:0] a);
        @(posedge clk);
        #1;
        s_if.tdata = {d, a};
        s_if.tvalid = 1'b1;
        wait_in_hs();
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !m_if.tvalid) return;
        end
        total++;
        bad++;
        $display("FAIL out_timeout: got %0d pending want 0", sb.size());
    endtask

    initial begin
        logic [W-1:0] da [6];
        logic [W-1:0] aa [6];
        da = '{16'd7, 16'd0, 16'd1, 16'd9, 16'hFFFF, 16'hFFFF};
        aa = '{16'd100, 16'h1234, 16'hFFFF, 16'd5, 16'hFFFF, 16'hFFFE};
        s_if.tvalid = 1'b0;
        s_if.tdata = '0;
        s_if.tuser = 1'b0;
        m_if.tready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_s_ready", 64'(s_if.tready), 64'd0);
        chk("rst_m_valid", 64'(m_if.tvalid), 64'd0);
        chk("rst_m_tdata", 64'(m_if.tdata), 64'd0);
        chk("rst_m_tuser", 64'(m_if.tuser), 64'd0);
        @(negedge clk);
        chk("rst_s_ready_up", 64'(s_if.tready), 64'd1);

        m_if.tready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send(da[i], aa[i]);
            wait_idle();
        end

        // Backpressure with a second beat waiting on the input.
        m_if.tready = 1'b0;
        send(16'd7, 16'd100);
        for (int i = 0; i < 40 && !m_if.tvalid; i++) @(negedge clk);
        chk("bp_valid_up", 64'(m_if.tvalid), 64'd1);
        @(posedge clk);
        #1;
        s_if.tdata = {16'd3, 16'd9};
        s_if.tvalid = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("bp_s_ready", 64'(s_if.tready), 64'd0);
            chk("bp_valid", 64'(m_if.tvalid), 64'd1);
        end
        @(posedge clk);
        #1;
        m_if.tready = 1'b1;
        wait_in_hs();
        wait_idle();

        // Reset during the fifth CALC cycle.
        send(16'd3, 16'd50000);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        n_in--;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", 64'(m_if.tvalid), 64'd0);
        chk("mid_rst_s_ready", 64'(s_if.tready), 64'd0);
        chk("mid_rst_tdata", 64'(m_if.tdata), 64'd0);
        chk("mid_rst_tuser", 64'(m_if.tuser), 64'd0);
        @(negedge clk);
        chk("mid_rst_s_ready_up", 64'(s_if.tready), 64'd1);
        send(16'd10, 16'd1000);
        wait_idle();

        // Random traffic with random backpressure.
        fork
            begin
                for (int n = 0; n < 2000; n++) begin
                    logic [W-1:0] d;
                    int sel;
                    repeat ($urandom % 2) @(posedge clk);
                    sel = $urandom % 10;
                    if (sel == 0) d = '0;
                    else if (sel < 3) d = W'($urandom % 16 + 1);
                    else d = W'($urandom);
                    send(d, W'($urandom));
                end
                done_r = 1'b1;
            end
            begin
                while (!done_r) begin
                    @(posedge clk);
                    #1;
                    m_if.tready = ($urandom % 4) != 0;
                end
            end
        join
        m_if.tready = 1'b1;
        wait_idle();
        chk("no_lost_beats", 64'(n_out), 64'(n_in));
        chk("random_beats_in", 64'(n_in), 64'd2009);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
